// File: rtl/dff_arb_pkg.sv
// Shared types and constants for the round-robin arbitrated storage register.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional stats feature is controlled by DFF_ARB_STATS_EN in dff_bank_arbiter.
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         STAT_W   = 8;
    localparam logic [7:0] STAT_MAX = 8'd255;

    // Pointer width; a single requester still needs one bit to index.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dff_arb_rr_pick.sv
// Round-robin picker: first set req at or after rr_ptr, searching upward with wrap.
// Latency: purely combinational, no state.
// Backpressure: none; any=0 when no request is pending.
module dff_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_id,
    output logic               any
);

    int idx;

    always_comb begin
        pick    = '0;
        pick_id = '0;
        any     = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_REQ;
            if (!any && req[idx]) begin
                any       = 1'b1;
                pick[idx] = 1'b1;
                pick_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Shares one DATA_W-bit register among NUM_REQ requesters via req/ack and round-robin grant.
// Latency: req -> gnt 1 cycle, req -> ack/q update 2 cycles; one write per 3 cycles.
// Backpressure: requesters hold req/wdata until ack; DFF_ARB_STATS_EN adds per-requester write counters.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int                NUM_REQ   = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           q,
`ifdef DFF_ARB_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0]   stat_cnt,
`endif
    output logic                        busy
);

    localparam int ID_W = id_w(NUM_REQ);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     gnt_id;
    logic [NUM_REQ-1:0]  pick;
    logic [ID_W-1:0]     pick_id;
    logic                any;
    logic                wr_done;

    dff_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .any     (any)
    );

    assign busy    = (state != IDLE);
    assign wr_done = (state == WRITE) && req[gnt_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            ack    <= '0;
            q      <= RESET_VAL;
            rr_ptr <= '0;
            gnt_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (any) begin
                        gnt    <= pick;
                        gnt_id <= pick_id;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (req[gnt_id]) begin
                        q      <= wdata[int'(gnt_id)*DATA_W +: DATA_W];
                        ack    <= gnt;
                        rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
                        state  <= DONE;
                    end else begin
                        // Granted requester withdrew: release without touching q or fairness.
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    ack   <= '0;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DFF_ARB_STATS_EN
    logic [STAT_W-1:0] cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else if (wr_done && cnt[gnt_id] != STAT_MAX) begin
            cnt[gnt_id] <= cnt[gnt_id] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_cnt[g*STAT_W +: STAT_W] = cnt[g];
    end
`else
    logic unused_wr_done;
    assign unused_wr_done = wr_done;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: reset, single write, round-robin, abort, mid-write reset, stats.
module tb_dff_bank_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   ack;
    logic [DW-1:0]   q;
    logic            busy;
`ifdef DFF_ARB_STATS_EN
    logic [NR*8-1:0] stat_cnt;
`endif

    int total = 0;
    int bad   = 0;

    dff_bank_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .RESET_VAL (RV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .ack      (ack),
        .q        (q),
`ifdef DFF_ARB_STATS_EN
        .stat_cnt (stat_cnt),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int i, input logic [7:0] v);
        wdata[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        req   = '0;
        wdata = '0;
        #2;

        // 1. Reset
        rst_n = 1'b0;
        #3;
        check("rst_q", 32'(q), 32'hA5);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 2. Single write from requester 2
        set_w(2, 8'h3C);
        req = 4'b0100;
        tick();
        check("sw_gnt", 32'(gnt), 32'b0100);
        check("sw_ack0", 32'(ack), 0);
        check("sw_busy", 32'(busy), 1);
        check("sw_q0", 32'(q), 32'hA5);
        tick();
        check("sw_q", 32'(q), 32'h3C);
        check("sw_ack", 32'(ack), 32'b0100);
        req = '0;
        tick();
        check("sw_gnt_clr", 32'(gnt), 0);
        check("sw_ack_clr", 32'(ack), 0);
        check("sw_idle", 32'(busy), 0);

        // 3. Round-robin from rr_ptr=0, all requesting
        do_reset();
        for (int i = 0; i < NR; i++) set_w(i, 8'h10 + 8'(i));
        req = 4'b1111;
        begin
            int order[5];
            order = '{0, 1, 2, 3, 0};
            for (int k = 0; k < 5; k++) begin
                tick();
                check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1) << order[k]);
                check($sformatf("rr_noack%0d", k), 32'(ack), 0);
                tick();
                check($sformatf("rr_ack%0d", k), 32'(ack), 32'(1) << order[k]);
                check($sformatf("rr_q%0d", k), 32'(q), 32'h10 + 32'(order[k]));
                req[order[k]] = 1'b0;
                tick();
                check($sformatf("rr_done%0d", k), 32'(ack | gnt), 0);
                req[order[k]] = 1'b1;
            end
        end
        req = '0;
        tick();

        // 4. Abort leaves q and rr_ptr alone
        do_reset();
        set_w(0, 8'h5A);
        set_w(1, 8'h77);
        req = 4'b0010;
        tick();
        check("ab_gnt", 32'(gnt), 32'b0010);
        req = '0;
        tick();
        check("ab_ack", 32'(ack), 0);
        check("ab_gnt_clr", 32'(gnt), 0);
        check("ab_idle", 32'(busy), 0);
        check("ab_q", 32'(q), 32'hA5);
        req = 4'b0011;
        tick();
        check("ab_next_gnt", 32'(gnt), 32'b0001);
        tick();
        check("ab_next_ack", 32'(ack), 32'b0001);
        check("ab_next_q", 32'(q), 32'h5A);
        req = '0;
        tick();

        // 5. Reset in the middle of a write
        set_w(2, 8'h99);
        req = 4'b0100;
        tick();
        check("mr_write", 32'(busy), 1);
        rst_n = 1'b0;
        #2;
        check("mr_q", 32'(q), 32'hA5);
        check("mr_ack", 32'(ack), 0);
        check("mr_gnt", 32'(gnt), 0);
        check("mr_busy", 32'(busy), 0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mr_idle", 32'(busy), 0);
        check("mr_q_hold", 32'(q), 32'hA5);
        set_w(3, 8'hC3);
        req = 4'b1000;
        tick();
        check("mr_new_gnt", 32'(gnt), 32'b1000);
        tick();
        check("mr_new_ack", 32'(ack), 32'b1000);
        check("mr_new_q", 32'(q), 32'hC3);
        req = '0;
        tick();

`ifdef DFF_ARB_STATS_EN
        // 6. Saturating write counters
        do_reset();
        check("st_rst", 32'(stat_cnt), 0);
        set_w(1, 8'h21);
        for (int n = 0; n < 300; n++) begin
            req = 4'b0010;
            tick();
            tick();
            req = '0;
            tick();
            if (n == 9) check("st_cnt10", 32'(stat_cnt), 32'h0000_0A00);
        end
        check("st_sat", 32'(stat_cnt[15:8]), 32'd255);
        check("st_others", 32'({stat_cnt[31:16], stat_cnt[7:0]}), 0);
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        check("st_abort", 32'(stat_cnt), 32'h0000_FF00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
